// File: rtl/life_engine.sv
// Game-of-Life generation engine for an 8x8 board.
// Computes one row per clock into a shadow grid, then commits atomically.
module life_engine #(
    parameter bit WRAP  = 1'b1,
    parameter int GEN_W = 16
) (
    input  logic             clk,
    input  logic             _rst,
    input  logic             step,
    input  logic             load,
    input  logic [2:0]       load_row,
    input  logic [7:0]       load_data,
    output logic [63:0]      grid,
    output logic             busy,
    output logic             done,
    output logic [GEN_W-1:0] gen,
    output logic             still,
    output logic             extinct
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CALC   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [63:0]      cur_q;
    logic [63:0]      nxt_q;
    logic [2:0]       r_q;
    logic [GEN_W-1:0] gen_q;
    logic             still_q;
    logic             done_q;
    logic [7:0]       row_d;

    function automatic logic cell_next(
        input logic [63:0] g,
        input logic [2:0]  r,
        input int          c
    );
        logic [3:0] n;
        int         rr;
        int         cc;
        logic       alive;
        n = 4'd0;
        for (int dr = -1; dr <= 1; dr++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                rr = int'(r) + dr;
                cc = c + dc;
                if (WRAP) begin
                    rr = rr & 7;
                    cc = cc & 7;
                end
                if ((dr != 0 || dc != 0) &&
                    rr >= 0 && rr <= 7 && cc >= 0 && cc <= 7) begin
                    n = n + {3'b000, g[6'(rr * 8 + cc)]};
                end
            end
        end
        alive = g[6'(int'(r) * 8 + c)];
        return (n == 4'd3) || (alive && n == 4'd2);
    endfunction

    for (genvar c = 0; c < 8; c++) begin : g_col
        assign row_d[c] = cell_next(cur_q, r_q, c);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (!load && step) state_d = S_CALC;
            S_CALC:   if (r_q == 3'd7) state_d = S_COMMIT;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            nxt_q   <= '0;
            r_q     <= '0;
            gen_q   <= '0;
            still_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == S_COMMIT);
            case (state_q)
                S_IDLE: begin
                    if (load) begin
                        cur_q[{load_row, 3'b000} +: 8] <= load_data;
                        gen_q   <= '0;
                        still_q <= 1'b0;
                    end else if (step) begin
                        r_q <= '0;
                    end
                end
                S_CALC: begin
                    nxt_q[{r_q, 3'b000} +: 8] <= row_d;
                    r_q <= r_q + 3'd1;
                end
                S_COMMIT: begin
                    cur_q   <= nxt_q;
                    still_q <= (nxt_q == cur_q);
                    gen_q   <= gen_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign grid    = cur_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign gen     = gen_q;
    assign still   = still_q;
    assign extinct = ~|cur_q;

endmodule

// File: tb/tb_life_engine.sv
// Bench for life_engine: toroidal, bounded and 2-bit-counter instances
// driven in parallel, checked against a reference Life model.
module tb_life_engine;

    logic        clk = 1'b0;
    logic        _rst;
    logic        step;
    logic        load;
    logic [2:0]  load_row;
    logic [7:0]  load_data;

    logic [63:0] grid1, grid0, grid2;
    logic        busy1, busy0, busy2;
    logic        done1, done0, done2;
    logic [15:0] gen1, gen0;
    logic [1:0]  gen2;
    logic        still1, still0, still2;
    logic        extinct1, extinct0, extinct2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    life_engine #(.WRAP(1'b1), .GEN_W(16)) dut1 (
        .clk(clk), ._rst(_rst), .step(step), .load(load),
        .load_row(load_row), .load_data(load_data),
        .grid(grid1), .busy(busy1), .done(done1), .gen(gen1),
        .still(still1), .extinct(extinct1)
    );

    life_engine #(.WRAP(1'b0), .GEN_W(16)) dut0 (
        .clk(clk), ._rst(_rst), .step(step), .load(load),
        .load_row(load_row), .load_data(load_data),
        .grid(grid0), .busy(busy0), .done(done0), .gen(gen0),
        .still(still0), .extinct(extinct0)
    );

    life_engine #(.WRAP(1'b1), .GEN_W(2)) dut2 (
        .clk(clk), ._rst(_rst), .step(step), .load(load),
        .load_row(load_row), .load_data(load_data),
        .grid(grid2), .busy(busy2), .done(done2), .gen(gen2),
        .still(still2), .extinct(extinct2)
    );

    typedef struct {
        logic [63:0] g1;
        logic [63:0] g0;
        int          gen;
        bit          st1;
    } exp_t;

    typedef struct {
        string       name;
        logic [63:0] seed;
        int          nsteps;
        logic [63:0] exp;
        bit          exp_still;
    } vec_t;

    exp_t        sbq[$];
    logic [63:0] m1, m0;
    int          mgen;

    task automatic chk(input string n, input logic [63:0] a,
                       input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    function automatic logic [63:0] row(input int r, input logic [7:0] d);
        logic [63:0] v;
        v = '0;
        v[r*8 +: 8] = d;
        return v;
    endfunction

    function automatic logic [63:0] life(input logic [63:0] g, input bit wrap);
        logic [63:0] res;
        int n, rr, cc;
        res = '0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr == 0 && dc == 0) continue;
                        rr = r + dr;
                        cc = c + dc;
                        if (wrap) begin
                            rr = (rr + 8) % 8;
                            cc = (cc + 8) % 8;
                        end else if (rr < 0 || rr > 7 || cc < 0 || cc > 7) begin
                            continue;
                        end
                        n += int'(g[rr*8 + cc]);
                    end
                end
                res[r*8 + c] = (n == 3) || (g[r*8 + c] && n == 2);
            end
        end
        return res;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        _rst = 1'b0;
        @(negedge clk);
        _rst = 1'b1;
        m1 = '0;
        m0 = '0;
        mgen = 0;
        sbq.delete();
    endtask

    task automatic do_load(input int r, input logic [7:0] d);
        @(negedge clk);
        load = 1'b1;
        load_row = 3'(r);
        load_data = d;
        @(negedge clk);
        load = 1'b0;
        m1[r*8 +: 8] = d;
        m0[r*8 +: 8] = d;
        mgen = 0;
    endtask

    task automatic do_step();
        exp_t e;
        int   k;
        bit   seen;
        logic [63:0] nx;
        @(negedge clk);
        step = 1'b1;
        nx = life(m1, 1'b1);
        e.st1 = (nx == m1);
        m1 = nx;
        m0 = life(m0, 1'b0);
        mgen++;
        e.g1 = m1;
        e.g0 = m0;
        e.gen = mgen;
        sbq.push_back(e);
        @(negedge clk);
        step = 1'b0;
        chk("busy_after_step", busy1, 1);
        seen = 1'b0;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done1) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", seen, 1);
        if (seen) begin
            chk("latency", k, 9);
            chk("busy_at_done", busy1, 0);
            if (sbq.size() == 0) begin
                chk("sb_nonempty", 0, 1);
            end else begin
                e = sbq.pop_front();
                chk("grid_wrap", grid1, e.g1);
                chk("grid_nowrap", grid0, e.g0);
                chk("grid_gen2", grid2, e.g1);
                chk("done_nowrap", done0, 1);
                chk("gen", gen1, e.gen);
                chk("gen2", gen2, e.gen % 4);
                chk("still", still1, e.st1);
                chk("extinct", extinct1, e.g1 == 0);
            end
        end
        @(negedge clk);
        chk("done_pulse", done1, 0);
    endtask

    vec_t        tv[4];
    logic [63:0] s, glider;
    int          dones, both, bz;

    initial begin
        glider = row(0, 8'b0000_0010) | row(1, 8'b0000_0100)
               | row(2, 8'b0000_0111);
        tv[0] = '{"blinker1", row(3, 8'h1C), 1,
                  row(2, 8'h08) | row(3, 8'h08) | row(4, 8'h08), 1'b0};
        tv[1] = '{"blinker2", row(3, 8'h1C), 2, row(3, 8'h1C), 1'b0};
        tv[2] = '{"block", row(1, 8'h06) | row(2, 8'h06), 1,
                  row(1, 8'h06) | row(2, 8'h06), 1'b1};
        tv[3] = '{"glider32", glider, 32, glider, 1'b0};

        _rst = 1'b0;
        step = 1'b0;
        load = 1'b0;
        load_row = '0;
        load_data = '0;
        #12;
        chk("rst_grid", grid1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_gen", gen1, 0);
        chk("rst_still", still1, 0);
        chk("rst_extinct", extinct1, 1);
        @(negedge clk);
        _rst = 1'b1;

        for (int i = 0; i < 4; i++) begin
            do_reset();
            s = tv[i].seed;
            for (int r = 0; r < 8; r++) do_load(r, s[r*8 +: 8]);
            chk({tv[i].name, "_loaded"}, grid1, s);
            chk({tv[i].name, "_load_gen"}, gen1, 0);
            repeat (tv[i].nsteps) do_step();
            chk({tv[i].name, "_grid"}, grid1, tv[i].exp);
            chk({tv[i].name, "_gen"}, gen1, tv[i].nsteps);
            chk({tv[i].name, "_still"}, still1, tv[i].exp_still);
            chk({tv[i].name, "_extinct"}, extinct1, 0);
        end

        // Bounded glider: must not wrap and ends as a block.
        do_reset();
        for (int r = 0; r < 8; r++) do_load(r, glider[r*8 +: 8]);
        repeat (32) do_step();
        chk("nowrap_differs", grid0 == glider, 0);
        chk("nowrap_pop", $countones(grid0), 4);
        chk("nowrap_still", still0, 1);
        chk("nowrap_gen", gen0, 32);

        // Step pulses while busy are dropped.
        do_reset();
        do_load(3, 8'h1C);
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        dones = 0;
        both = 0;
        for (int k = 1; k <= 14; k++) begin
            step = (k <= 6);
            @(negedge clk);
            if (done1) dones++;
            if (done1 && busy1) both++;
        end
        step = 1'b0;
        chk("hs_dones", dones, 1);
        chk("hs_done_busy", both, 0);
        chk("hs_gen", gen1, 1);
        chk("hs_grid", grid1, row(2, 8'h08) | row(3, 8'h08) | row(4, 8'h08));

        // Load and step together: load wins.
        do_reset();
        do_step();
        @(negedge clk);
        load = 1'b1;
        step = 1'b1;
        load_row = 3'd5;
        load_data = 8'hA5;
        @(negedge clk);
        load = 1'b0;
        step = 1'b0;
        chk("ls_busy", busy1, 0);
        chk("ls_gen", gen1, 0);
        chk("ls_grid", grid1, row(5, 8'hA5));
        dones = 0;
        bz = 0;
        repeat (12) begin
            @(negedge clk);
            if (done1) dones++;
            if (busy1) bz++;
        end
        chk("ls_no_done", dones, 0);
        chk("ls_no_busy", bz, 0);

        // Reset in the middle of CALC.
        do_reset();
        do_load(3, 8'h1C);
        do_step();
        @(negedge clk);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (3) @(negedge clk);
        #2 _rst = 1'b0;
        #1;
        chk("mr_grid", grid1, 0);
        chk("mr_busy", busy1, 0);
        chk("mr_gen", gen1, 0);
        chk("mr_extinct", extinct1, 1);
        @(negedge clk);
        _rst = 1'b1;
        m1 = '0;
        m0 = '0;
        mgen = 0;
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done1) dones++;
        end
        chk("mr_no_done", dones, 0);
        chk("mr_grid_after", grid1, 0);

        // 2-bit generation counter wraps on an empty grid.
        do_reset();
        for (int j = 0; j < 4; j++) begin
            do_step();
            chk("cw_gen2", gen2, (j + 1) % 4);
            chk("cw_still2", still2, 1);
            chk("cw_extinct2", extinct2, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
